mux4_rr_arbiter: RTL
====================

# mux4_rr_arbiter

Round-robin arbiter and sequencer for the 4:1 one-bit multiplexer datapath. It shares the mux between four requesters, drives the select lines, and registers the selected data bit for the consumer. The block replaces the free-running testbench select stepping with a request/grant controller, so the mux can be reused as a shared resource in lab designs.

## Interface
- `HOLD_MAX`, default 8: maximum consecutive cycles one requester may keep the grant while others are waiting. Legal range is ≥1. Used only when `MUX4_ARB_HOLD_LIMIT_EN` is defined.
- `clk`  input  1  rising-edge clock; the single clock domain.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `req`  input  4  per-requester request; `req[i]` is held high while requester i wants the mux.
- `din`  input  4  data bits; `din[0]`..`din[3]` correspond to mux inputs a..d.
- `gnt`  output  4  one-hot grant, or all zeros when idle; registered.
- `sel`  output  2  mux select, `{s1,s0}` = index of the granted requester; registered.
- `y`  output  1  registered mux output, equal to `din[sel]` sampled one cycle after the grant.
- `y_valid`  output  1  `y` holds data for the current grant.

## Operation
- States:
  - IDLE: `gnt` = 0.
  - GRANT: exactly one `gnt` bit is set.
- Round-robin pointer `ptr` (2 bits) holds the last granted index.
  - Search order is `ptr+1`, `ptr+2`, `ptr+3`, `ptr`, modulo 4, with wrap-around.
  - Reset value is 3, so `req[0]` has the highest priority first.
- IDLE → GRANT: when any `req` bit is set, grant the first requester in search order. Set `sel` and `ptr` to that index and clear the hold counter.
- GRANT, current requester `c`:
  - `req[c]`=1 and no hold-limit expiry: remain in GRANT and increment the hold counter, saturating at `HOLD_MAX`.
  - `req[c]`=0 and other requests are pending: switch directly to the next requester in search order, with no idle cycle. Clear the counter.
  - `req[c]`=0 and no other requests: return to IDLE with `gnt`=0. `sel` keeps its last value.
  - Hold counter = `HOLD_MAX`, `req[c]`=1, and another request is pending: revoke and grant the next requester in search order, skipping `c`.
  - Hold counter = `HOLD_MAX`, `req[c]`=1, and no other request: keep the grant.
- `y` loads `din[sel_next]`'s mux result on each cycle the next state is GRANT.
  - `y_valid` is registered `gnt != 0` from the previous cycle and drops together with `gnt`.
  - During IDLE, `y` holds its last value.
- Simultaneous requests: resolved only by the round-robin order, never by index priority alone.
- Counter width is `$clog2(HOLD_MAX+1)`. No overflow is possible because the counter saturates.

## Timing
- Reset (asynchronous, any cycle, including mid-grant):
  - `gnt`=0, `sel`=0, `y`=0, `y_valid`=0.
  - `ptr`=3, counter=0, state IDLE.
- After `rst_n` deasserts, the first active edge evaluates requests normally.
- Latency:
  - `req` rising to `gnt` rising: 1 cycle.
  - `gnt` to `y_valid`: 1 cycle.
  - `req` falling to `gnt` falling or switching: 1 cycle.
- Handshake rules:
  - A requester must keep `req` high until it sees its `gnt`.
  - The requester owns the mux while `gnt` is high.
  - Dropping `req` releases the mux on the next edge.
- `gnt`, `sel` and `y` change only on the rising edge of `clk`.

## Configuration
- `MUX4_ARB_HOLD_LIMIT_EN` defined: the `HOLD_MAX` fairness revocation is active as described above.
- Undefined: there is no hold counter, and a grant is held until the owner drops `req`. The `HOLD_MAX` parameter is ignored. All other behaviour is identical.

## Structure
- Shared package `mux4_arb_pkg` contains:
  - the state enum (`ARB_IDLE`, `ARB_GRANT`);
  - the constant `N_REQ`=4;
  - a `rr_next(req, ptr, exclude)` function.
- One natural sub-module, `mux4_sel`: the combinational 4:1 data mux with `sel` driving `{s1,s0}`. It is instantiated once; its output feeds the `y` register.

## Test plan
- Reset mid-grant: `req`=0001 granted, then pull `rst_n` low → `gnt`=0, `sel`=0, `y_valid`=0 immediately. After release, `req`=0010 → `gnt`=0010.
- Single request: `din`=1101, `req`=0100 → `gnt`=0100 and `sel`=2 one cycle later; `y`=1 and `y_valid`=1 the cycle after that.
- Round robin: `req`=1111 from reset, each owner drops `req` after 2 cycles of grant → grant order is 0,1,2,3,0, with no idle cycles between grants.
- Hold limit, with the macro defined and `HOLD_MAX`=4: `req[1]` held high, `req[3]` raised → `gnt` moves to 1000 after the counter reaches 4. Repeating this with the macro undefined → `gnt` stays 0010 until `req[1]` drops.
- Release with nothing pending: sole owner `req`=0001 drops → `gnt`=0 and `y_valid`=0 next cycle, `y` holds its value, `sel` stays 0.
- Select mapping: `din`=1011 with each requester granted in turn → `y` sequence 1,1,0,1 matching inputs a..d.

Source files
------------

// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the 4:1 mux round-robin arbiter.
// Holds the arbiter state enum, requester count and the round-robin
// search function used by the next-state logic.
package mux4_arb_pkg;

  localparam int N_REQ = 4;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Result of a round-robin search: vld=0 means nobody matched.
  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
  } rr_pick_t;

  // Search ptr+1, ptr+2, ptr+3, ptr (mod 4) and return the first requester
  // found. With exclude set, ptr itself is left out of the search.
  function automatic rr_pick_t rr_next(input logic [N_REQ-1:0] req,
                                       input logic [1:0]       ptr,
                                       input logic             exclude);
    rr_pick_t   pick;
    logic [1:0] idx;
    pick = '0;
    // Walk the order backwards so the earliest position in the order wins.
    for (int k = N_REQ; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx] && !(exclude && (k == N_REQ))) begin
        pick.vld = 1'b1;
        pick.idx = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux4_sel.sv
// Combinational 4:1 one-bit data mux; sel = {s1,s0} picks din[sel].
// Ports: din[3:0] data inputs a..d, sel[1:0] select, y selected bit.
// Purely combinational, no clock or reset.
module mux4_sel
  import mux4_arb_pkg::*;
(
  input  logic [N_REQ-1:0] din,
  input  logic [1:0]       sel,
  output logic             y
);

  always_comb begin
    y = 1'b0;
    case (sel)
      2'd0:    y = din[0];
      2'd1:    y = din[1];
      2'd2:    y = din[2];
      default: y = din[3];
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin request/grant controller sharing one 4:1 data mux between
// four requesters; gnt/sel registered (1 cycle after req), y registered at
// the grant edge, y_valid one cycle after gnt and dropping together with it.
// Ports: clk, rst_n (async active-low), req[3:0], din[3:0] in;
//        gnt[3:0] one-hot, sel[1:0], y, y_valid out.
// Optional macro MUX4_ARB_HOLD_LIMIT_EN: revoke a grant held HOLD_MAX cycles
// while others wait; without it a grant lasts until the owner drops req.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] din,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       sel,
  output logic             y,
  output logic             y_valid
);

  if (HOLD_MAX < 1) begin : g_hold_max_check
    $error("HOLD_MAX must be at least 1");
  end

  arb_state_t       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;       // last granted index; owner while in GRANT
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic             mux_y;
  logic             hold_expired;
  rr_pick_t         pick_any, pick_oth;

`ifdef MUX4_ARB_HOLD_LIMIT_EN
  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             others_pend;

  assign others_pend  = |(req & ~(N_REQ'(1) << ptr_q));
  assign hold_expired = (cnt_q == CNT_W'(HOLD_MAX)) && others_pend;
`else
  assign hold_expired = 1'b0;
`endif

  assign pick_any = rr_next(req, ptr_q, 1'b0);
  assign pick_oth = rr_next(req, ptr_q, 1'b1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= 2'd3;
      gnt_q     <= '0;
      sel_q     <= '0;
      y_q       <= 1'b0;
      y_valid_q <= 1'b0;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_any.vld) begin
          state_d = ARB_GRANT;
          ptr_d   = pick_any.idx;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
          cnt_d   = '0;
`endif
        end
      end
      default: begin
        if (req[ptr_q] && !hold_expired) begin
`ifdef MUX4_ARB_HOLD_LIMIT_EN
          if (cnt_q != CNT_W'(HOLD_MAX)) cnt_d = cnt_q + CNT_W'(1);
`endif
        end else if (pick_oth.vld) begin
          // Owner released or was revoked: hand over without an idle cycle.
          ptr_d = pick_oth.idx;
`ifdef MUX4_ARB_HOLD_LIMIT_EN
          cnt_d = '0;
`endif
        end else begin
          state_d = ARB_IDLE;
        end
      end
    endcase
  end

  // The mux looks at the select that is about to be registered, so y is
  // loaded at the same edge that raises or moves the grant.
  mux4_sel u_mux4_sel (
    .din (din),
    .sel (sel_d),
    .y   (mux_y)
  );

  // Output logic
  always_comb begin
    gnt_d     = '0;
    sel_d     = sel_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    if (state_d == ARB_GRANT) begin
      gnt_d = N_REQ'(1) << ptr_d;
      sel_d = ptr_d;
      y_d   = mux_y;
    end
    // Valid from the second granted cycle on, cleared in step with gnt.
    y_valid_d = (state_q == ARB_GRANT) && (state_d == ARB_GRANT);
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;

endmodule
